// File: rtl/tdm_pkg.sv
// rtl/tdm_pkg.sv - shared types and constants for the TDM demultiplexer
package tdm_pkg;

  localparam int TDM_MAX_CH = 16;

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } tdm_state_e;

  // Slot counter width; a single-channel frame still needs one counter bit.
  function automatic int slot_width(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/tdm_slot_decoder.sv
// rtl/tdm_slot_decoder.sv - one-hot staging-slot write strobe from slot index
module tdm_slot_decoder
  import tdm_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int CW   = slot_width(N_CH)
) (
  input  logic [CW-1:0]   slot_i,
  input  logic            en_i,
  output logic [N_CH-1:0] we_o
);

  for (genvar k = 0; k < N_CH; k++) begin : g_we
    assign we_o[k] = en_i && (slot_i == CW'(k));
  end

endmodule

// File: rtl/tdm_demux.sv
// rtl/tdm_demux.sv - frame-locking TDM demultiplexer: serial beats to parallel frame
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic [W-1:0]      in_data,
  output logic              out_valid,
  output logic [N_CH*W-1:0] out_data,
  output logic              locked,
  output logic              sync_err
);

  localparam int            CW   = slot_width(N_CH);
  localparam logic [CW-1:0] LAST = CW'(N_CH - 1);

  tdm_state_e        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [N_CH*W-1:0] stage_q, stage_d;
  logic [N_CH*W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              sync_err_q, sync_err_d;

  logic              wr_en;
  logic [CW-1:0]     wr_slot;
  logic [N_CH-1:0]   slot_we;
  logic              frame_done;

  function automatic logic [CW-1:0] next_slot(input logic [CW-1:0] c);
    return (c == LAST) ? '0 : c + CW'(1);
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_en      = 1'b0;
    wr_slot    = '0;
    sync_err_d = 1'b0;
    if (in_valid) begin
      unique case (state_q)
        HUNT: begin
          if (in_sof) begin
            wr_en   = 1'b1;
            cnt_d   = next_slot('0);
            state_d = RUN;
          end
        end
        RUN: begin
          if (in_sof) begin
            // An early SOF restarts the frame; the partial frame can never be
            // emitted because completion requires reaching the last slot again.
            sync_err_d = (cnt_q != '0);
            wr_en      = 1'b1;
            cnt_d      = next_slot('0);
          end else if (cnt_q != '0) begin
            wr_en   = 1'b1;
            wr_slot = cnt_q;
            cnt_d   = next_slot(cnt_q);
          end else begin
            sync_err_d = 1'b1;
            cnt_d      = '0;
            state_d    = HUNT;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  tdm_slot_decoder #(
    .N_CH (N_CH),
    .CW   (CW)
  ) u_slot_decoder (
    .slot_i (wr_slot),
    .en_i   (wr_en),
    .we_o   (slot_we)
  );

  always_comb begin
    stage_d = stage_q;
    for (int k = 0; k < N_CH; k++) begin
      if (slot_we[k]) stage_d[k*W +: W] = in_data;
    end
  end

  assign frame_done  = wr_en && (wr_slot == LAST);
  assign out_valid_d = frame_done;
  assign out_data_d  = frame_done ? stage_d : out_data_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      cnt_q       <= '0;
      stage_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stage_q     <= stage_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      sync_err_q  <= sync_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign locked    = (state_q == RUN);
  assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_tdm_demux.sv
// tb/tb_tdm_demux.sv - directed self-checking bench for tdm_demux (N_CH=4 and N_CH=1)
module tb_tdm_demux;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        in_valid, in_sof;
  logic [7:0]  in_data;
  logic        out_valid, locked, sync_err;
  logic [31:0] out_data;

  logic        in_valid1, in_sof1;
  logic [7:0]  in_data1;
  logic        out_valid1, locked1, sync_err1;
  logic [7:0]  out_data1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  tdm_demux #(.N_CH(4), .W(8)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .locked    (locked),
    .sync_err  (sync_err)
  );

  tdm_demux #(.N_CH(1), .W(8)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid1),
    .in_sof    (in_sof1),
    .in_data   (in_data1),
    .out_valid (out_valid1),
    .out_data  (out_data1),
    .locked    (locked1),
    .sync_err  (sync_err1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one beat for exactly one edge; returns 1 time unit after that edge.
  task automatic send(input logic sof, input logic [7:0] d);
    in_valid = 1'b1;
    in_sof   = sof;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic send1(input logic sof, input logic [7:0] d);
    in_valid1 = 1'b1;
    in_sof1   = sof;
    in_data1  = d;
    @(posedge clk);
    #1;
    in_valid1 = 1'b0;
    in_sof1   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    in_data   = '0;
    in_valid1 = 1'b0;
    in_sof1   = 1'b0;
    in_data1  = '0;
    idle(2);
    check("reset_out_data", out_data, 32'h0);
    check("reset_out_valid", {31'b0, out_valid}, 32'h0);
    check("reset_locked", {31'b0, locked}, 32'h0);
    check("reset_sync_err", {31'b0, sync_err}, 32'h0);
    rst_n = 1'b1;
    idle(1);

    // Back-to-back frame
    send(1'b1, 8'h11);
    check("b2b_locked", {31'b0, locked}, 32'h1);
    send(1'b0, 8'h22);
    send(1'b0, 8'h33);
    check("b2b_no_early_valid", {31'b0, out_valid}, 32'h0);
    send(1'b0, 8'h44);
    check("b2b_valid", {31'b0, out_valid}, 32'h1);
    check("b2b_data", out_data, 32'h44332211);
    check("b2b_sync_err", {31'b0, sync_err}, 32'h0);
    idle(1);
    check("b2b_valid_pulse", {31'b0, out_valid}, 32'h0);
    check("b2b_data_hold", out_data, 32'h44332211);

    // Same shape with idle gaps, distinct payload
    send(1'b1, 8'h5a);
    idle(2);
    send(1'b0, 8'h6b);
    idle(3);
    send(1'b0, 8'h7c);
    check("gap_no_valid", {31'b0, out_valid}, 32'h0);
    idle(1);
    send(1'b0, 8'h8d);
    check("gap_valid", {31'b0, out_valid}, 32'h1);
    check("gap_data", out_data, 32'h8d7c6b5a);
    idle(1);
    check("gap_valid_pulse", {31'b0, out_valid}, 32'h0);

    // Missing SOF at slot 0 while locked
    send(1'b0, 8'h55);
    check("miss_sync_err", {31'b0, sync_err}, 32'h1);
    check("miss_locked", {31'b0, locked}, 32'h0);
    check("miss_no_valid", {31'b0, out_valid}, 32'h0);
    idle(1);
    check("miss_sync_err_pulse", {31'b0, sync_err}, 32'h0);

    // HUNT discards non-SOF beats silently, then relocks
    send(1'b0, 8'haa);
    check("hunt_no_err_a", {31'b0, sync_err}, 32'h0);
    send(1'b0, 8'hbb);
    check("hunt_no_err_b", {31'b0, sync_err}, 32'h0);
    check("hunt_unlocked", {31'b0, locked}, 32'h0);
    send(1'b1, 8'h01);
    check("hunt_relock", {31'b0, locked}, 32'h1);
    send(1'b0, 8'h02);
    send(1'b0, 8'h03);
    send(1'b0, 8'h04);
    check("hunt_valid", {31'b0, out_valid}, 32'h1);
    check("hunt_data", out_data, 32'h04030201);
    check("hunt_sync_err", {31'b0, sync_err}, 32'h0);

    // Early SOF restarts the frame
    send(1'b1, 8'h01);
    send(1'b0, 8'h02);
    send(1'b1, 8'h10);
    check("early_sync_err", {31'b0, sync_err}, 32'h1);
    check("early_locked", {31'b0, locked}, 32'h1);
    send(1'b0, 8'h20);
    check("early_sync_err_pulse", {31'b0, sync_err}, 32'h0);
    send(1'b0, 8'h30);
    check("early_no_valid", {31'b0, out_valid}, 32'h0);
    send(1'b0, 8'h40);
    check("early_valid", {31'b0, out_valid}, 32'h1);
    check("early_data", out_data, 32'h40302010);

    // Reset in the middle of a frame
    send(1'b1, 8'hc1);
    send(1'b0, 8'hc2);
    rst_n = 1'b0;
    idle(1);
    check("midrst_out_data", out_data, 32'h0);
    check("midrst_out_valid", {31'b0, out_valid}, 32'h0);
    check("midrst_locked", {31'b0, locked}, 32'h0);
    rst_n = 1'b1;
    send(1'b0, 8'hc3);
    send(1'b0, 8'hc4);
    check("midrst_no_leak", {31'b0, out_valid}, 32'h0);
    send(1'b1, 8'hd1);
    send(1'b0, 8'hd2);
    send(1'b0, 8'hd3);
    send(1'b0, 8'hd4);
    check("midrst_valid", {31'b0, out_valid}, 32'h1);
    check("midrst_data", out_data, 32'hd4d3d2d1);

    // Back-to-back frames: completion and next slot-0 store on consecutive edges
    send(1'b1, 8'he1);
    check("b2b2_valid_gone", {31'b0, out_valid}, 32'h0);
    send(1'b0, 8'he2);
    send(1'b0, 8'he3);
    send(1'b0, 8'he4);
    check("b2b2_data", out_data, 32'he4e3e2e1);

    // Single-channel instance
    send1(1'b1, 8'h3c);
    check("n1_valid_a", {31'b0, out_valid1}, 32'h1);
    check("n1_data_a", {24'b0, out_data1}, 32'h3c);
    check("n1_locked", {31'b0, locked1}, 32'h1);
    send1(1'b1, 8'ha5);
    check("n1_valid_b", {31'b0, out_valid1}, 32'h1);
    check("n1_data_b", {24'b0, out_data1}, 32'ha5);
    check("n1_sync_err_b", {31'b0, sync_err1}, 32'h0);
    send1(1'b0, 8'h77);
    check("n1_miss_err", {31'b0, sync_err1}, 32'h1);
    check("n1_miss_unlocked", {31'b0, locked1}, 32'h0);
    check("n1_miss_no_valid", {31'b0, out_valid1}, 32'h0);
    check("n1_miss_hold", {24'b0, out_data1}, 32'ha5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tdm_demux.md
# tdm_demux

Receive-side counterpart of the selector/mux family: a time-division demultiplexer that takes a serial stream of W-bit beats, one per channel in order 0..N_CH-1 with a start-of-frame marker on channel 0, and distributes them to N_CH parallel, registered channel outputs. It sits at the far end of a TDM link, where a mux-based serializer interleaves channels onto one bus. It also locks to the frame, reports framing errors and presents each complete frame as one parallel word with a one-cycle valid pulse.

## Interface
- N_CH, default 4: channels per frame; legal range 1..16.
- W, default 8: bits per channel beat.

- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  beat present on in_data this cycle; no backpressure.
- in_sof  input  1  beat is channel 0 (start of frame); ignored when in_valid=0.
- in_data  input  W  beat payload.
- out_valid  output  1  one-cycle pulse: out_data holds a new complete frame.
- out_data  output  N_CH*W  channel k at bits [k*W +: W]; holds until next frame.
- locked  output  1  demux is in RUN state.
- sync_err  output  1  one-cycle pulse on framing violation.

## Operation
- Reset (rst_n=0 at a clock edge): state HUNT, slot counter 0, staging buffer 0, out_data 0, out_valid 0, locked 0, sync_err 0.
- Slot counter width: $clog2(N_CH), minimum 1 bit; wraps N_CH-1 -> 0.
- HUNT: beats without in_sof are discarded silently (no sync_err). Beat with in_sof: store in slot 0, counter -> 1 (wrap to 0 if N_CH=1), go RUN.
- RUN, valid beat with counter=c:
  - in_sof=0, c!=0: store in slot c, counter increments.
  - in_sof=1, c=0: normal frame start; store in slot 0, counter -> 1.
  - in_sof=1, c!=0 (early SOF): sync_err pulse, partial frame discarded, beat stored as slot 0, counter -> 1, stay RUN.
  - in_sof=0, c=0 (missing SOF): sync_err pulse, beat discarded, go HUNT, counter 0.
- Beat stored in slot N_CH-1 completes a frame: next cycle out_data = all N_CH slots (that last beat included), out_valid=1.
- N_CH=1: every beat must carry in_sof; each such beat produces a frame; a beat without in_sof in RUN is a missing-SOF error.
- in_valid=0: no state change; gaps between beats of any length are legal.
- Staging slots not written in the current frame never leak: a frame is emitted only after slots 0..N_CH-1 were written in order since the last SOF.

## Timing
- Latency: out_valid and new out_data appear exactly 1 cycle after the clock edge that accepts the last beat of a frame.
- Throughput: one beat per cycle, back-to-back frames with no idle cycle; out_valid may pulse every N_CH cycles (every cycle for N_CH=1).
- sync_err registered: asserted in the cycle after the offending beat, for one cycle.
- locked: registered state decode; rises 1 cycle after the accepted SOF in HUNT, falls 1 cycle after a missing-SOF beat.
- Reset mid-frame: partial frame dropped, no out_valid, out_data cleared to 0 on the reset edge.
- Simultaneous frame completion and the next beat: completion of frame n and slot-0 store of frame n+1 occur on consecutive edges without conflict; out_data register is separate from the staging buffer.

## Structure
- Package tdm_pkg: state enum typedef (HUNT, RUN), max-channel constant 16.
- One sub-module, tdm_slot_decoder: combinational 1-to-N_CH one-hot write-enable decoder (counter, enable -> per-slot write strobe), the demux dual of the mux primitive.
- Top: FSM, slot counter, staging buffer, output register, error logic.

## Test plan
- N_CH=4, W=8: beats (sof)11,22,33,44 back-to-back -> 1 cycle after 44, out_valid=1, out_data=32'h44332211, locked=1, sync_err never set.
- Same frame with idle cycles between every beat -> identical out_data, single out_valid pulse 1 cycle after 44.
- HUNT: beats AA,BB (no sof) then (sof)01,02,03,04 -> no sync_err, out_data=32'h04030201.
- Early SOF: (sof)01,02,(sof)10,20,30,40 -> sync_err pulse after third beat, single frame 32'h40302010.
- Missing SOF: full frame then 55 without sof -> sync_err, locked=0; following (sof)frame relocks and outputs normally.
- rst_n=0 after two beats of a frame -> out_data=0, out_valid=0, locked=0; next full frame outputs correctly; N_CH=1 run: each (sof)beat X gives out_data=X next cycle.
